// File: rtl/fxp_pkg.sv
// Shared Q16.16 fixed-point types and helpers for the order generation path.
// Holds the order FSM state encoding, side encoding and default thresholds.
package fxp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_HALTED   = 2'd3
    } order_state_t;

    typedef enum logic {
        SIDE_SELL = 1'b0,
        SIDE_BUY  = 1'b1
    } order_side_t;

    localparam logic signed [31:0] BUY_THRESH_DEFAULT  = 32'sh0000_8000;
    localparam logic signed [31:0] SELL_THRESH_DEFAULT = 32'shFFFF_8000;

    // Two's-complement magnitude; the most negative value has no positive
    // counterpart, so it saturates to the largest positive value.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
        if (v == 32'sh8000_0000) return 32'h7FFF_FFFF;
        else if (v < 0)          return 32'(-v);
        else                     return 32'(v);
    endfunction

endpackage

// File: rtl/order_gen_if.sv
// Sample-in and order-out handshake bundle between the signal source,
// order_gen and the downstream order consumer.
interface order_gen_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] signal_in;
    logic        allow_trade_in;
    logic        kill_switch_in;

    logic        order_valid;
    logic        order_ready;
    logic        order_side;
    logic [15:0] order_qty;
    logic [15:0] order_seq;

    modport master (
        output in_valid, signal_in, allow_trade_in, kill_switch_in, order_ready,
        input  in_ready, order_valid, order_side, order_qty, order_seq
    );

    modport slave (
        input  in_valid, signal_in, allow_trade_in, kill_switch_in, order_ready,
        output in_ready, order_valid, order_side, order_qty, order_seq
    );

endinterface

// File: rtl/order_gen.sv
// Converts Q16.16 trade signals into buy/sell orders with a post-order
// cooldown, risk gating, a latched kill halt and a suppressed-crossing counter.
module order_gen
    import fxp_pkg::*;
#(
    parameter logic signed [31:0] BUY_THRESH      = BUY_THRESH_DEFAULT,
    parameter logic signed [31:0] SELL_THRESH     = SELL_THRESH_DEFAULT,
    parameter int                 COOLDOWN_CYCLES = 4,
    parameter int                 MAX_QTY         = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt_clear,
    order_gen_if.slave  bus,
    output logic        halted,
    output logic [15:0] drop_count
);

    localparam logic [15:0] CD_LOAD = 16'(COOLDOWN_CYCLES);
    localparam logic [15:0] QTY_MAX = 16'(MAX_QTY);

    order_state_t state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         accept, handshake;
    logic         buy_x, sell_x, crossing;
    logic         load_order, drop_inc;
    logic [31:0]  mag;
    logic [15:0]  int_part, qty_c;

    assign accept    = bus.in_valid && bus.in_ready;
    assign handshake = bus.order_valid && bus.order_ready;

    assign buy_x    = $signed(bus.signal_in) >= BUY_THRESH;
    assign sell_x   = $signed(bus.signal_in) <= SELL_THRESH;
    assign crossing = buy_x || sell_x;

    assign mag      = abs_sat(bus.signal_in);
    assign int_part = mag[31:16];
    assign qty_c    = (int_part == 16'd0)    ? 16'd1 :
                      (int_part > QTY_MAX)   ? QTY_MAX : int_part;

    assign bus.in_ready    = (state_q != ST_HOLD);
    assign bus.order_valid = (state_q == ST_HOLD);
    assign halted          = (state_q == ST_HALTED);

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_order = 1'b0;
        drop_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.kill_switch_in) begin
                        state_d = ST_HALTED;
                    end else if (crossing && bus.allow_trade_in) begin
                        state_d    = ST_HOLD;
                        load_order = 1'b1;
                    end else if (crossing) begin
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    state_d = (CD_LOAD == 16'd0) ? ST_IDLE : ST_COOLDOWN;
                    cnt_d   = CD_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (accept && bus.kill_switch_in) begin
                    state_d = ST_HALTED;
                    cnt_d   = 16'd0;
                end else begin
                    drop_inc = accept && crossing;
                    if (cnt_q <= 16'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            ST_HALTED: begin
                // A kill arriving with the clear keeps the block halted.
                if (halt_clear && !(accept && bus.kill_switch_in))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.order_side <= SIDE_SELL;
            bus.order_qty  <= 16'd0;
            bus.order_seq  <= 16'd0;
            drop_count     <= 16'd0;
        end else begin
            if (load_order) begin
                bus.order_side <= buy_x ? SIDE_BUY : SIDE_SELL;
                bus.order_qty  <= qty_c;
            end
            if (handshake)
                bus.order_seq <= bus.order_seq + 16'd1;
            if (drop_inc && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_order_gen.sv
// Directed self-checking bench for order_gen with default parameters
// (COOLDOWN_CYCLES = 4, MAX_QTY = 100, thresholds +/-0.5).
module tb_order_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt_clear = 1'b0;
    logic        halted;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    order_gen_if bus ();

    order_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .halt_clear (halt_clear),
        .bus        (bus),
        .halted     (halted),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.signal_in      = 32'd0;
        bus.allow_trade_in = 1'b0;
        bus.kill_switch_in = 1'b0;
        bus.order_ready    = 1'b0;
        halt_clear         = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic drive_sample(input logic [31:0] sig, input logic allow, input logic kill);
        int waited = 0;
        while (!bus.in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid       = 1'b1;
        bus.signal_in      = sig;
        bus.allow_trade_in = allow;
        bus.kill_switch_in = kill;
        step();
        bus.in_valid       = 1'b0;
        bus.signal_in      = 32'd0;
        bus.allow_trade_in = 1'b0;
        bus.kill_switch_in = 1'b0;
    endtask

    // Handshake the pending order, then sit out the 4-cycle cooldown.
    task automatic take_order();
        bus.order_ready = 1'b1;
        step();
        bus.order_ready = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        do_reset();
        rst_n = 1'b0;
        check("rst_in_ready",    32'(bus.in_ready),    32'd1);
        check("rst_order_valid", 32'(bus.order_valid), 32'd0);
        check("rst_side",        32'(bus.order_side),  32'd0);
        check("rst_qty",         32'(bus.order_qty),   32'd0);
        check("rst_seq",         32'(bus.order_seq),   32'd0);
        check("rst_halted",      32'(halted),          32'd0);
        check("rst_drop",        32'(drop_count),      32'd0);
        rst_n = 1'b1;
        step();

        // +2.5 buy, one-cycle latency
        drive_sample(32'h0002_8000, 1'b1, 1'b0);
        check("buy25_valid", 32'(bus.order_valid), 32'd1);
        check("buy25_side",  32'(bus.order_side),  32'd1);
        check("buy25_qty",   32'(bus.order_qty),   32'd2);
        check("buy25_seq",   32'(bus.order_seq),   32'd0);
        take_order();

        // -16 sell held under backpressure
        do_reset();
        drive_sample(32'hFFF0_0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("sell16_valid",    32'(bus.order_valid), 32'd1);
            check("sell16_side",     32'(bus.order_side),  32'd0);
            check("sell16_qty",      32'(bus.order_qty),   32'd16);
            check("sell16_in_ready", 32'(bus.in_ready),    32'd0);
            step();
        end
        check("sell16_seq_before", 32'(bus.order_seq), 32'd0);
        bus.order_ready = 1'b1;
        step();
        bus.order_ready = 1'b0;
        check("sell16_seq_after",   32'(bus.order_seq),   32'd1);
        check("sell16_valid_after", 32'(bus.order_valid), 32'd0);
        check("sell16_in_ready_cd", 32'(bus.in_ready),    32'd1);

        // back-to-back buys: cooldown suppression and exact cooldown length
        do_reset();
        bus.order_ready = 1'b1;
        drive_sample(32'h0001_0000, 1'b1, 1'b0);
        check("b2b_first_valid", 32'(bus.order_valid), 32'd1);
        check("b2b_first_qty",   32'(bus.order_qty),   32'd1);
        step();
        check("b2b_seq1", 32'(bus.order_seq), 32'd1);
        drive_sample(32'h0001_0000, 1'b1, 1'b0);
        check("b2b_second_valid", 32'(bus.order_valid), 32'd0);
        check("b2b_drop1",        32'(drop_count),      32'd1);
        step();
        step();
        drive_sample(32'h0001_0000, 1'b1, 1'b0);
        check("cd_last_valid", 32'(bus.order_valid), 32'd0);
        check("cd_last_drop",  32'(drop_count),      32'd2);
        drive_sample(32'h0001_0000, 1'b1, 1'b0);
        check("cd_over_valid", 32'(bus.order_valid), 32'd1);
        step();
        check("cd_over_seq", 32'(bus.order_seq), 32'd2);
        drive_sample(32'h0001_0000, 1'b1, 1'b1);
        check("cd_kill_halted", 32'(halted),     32'd1);
        check("cd_kill_drop",   32'(drop_count), 32'd2);
        bus.order_ready = 1'b0;

        // kill in IDLE, halted discards samples, halt_clear releases
        do_reset();
        drive_sample(32'h0000_0000, 1'b0, 1'b1);
        check("kill_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive_sample(32'h0005_0000, 1'b1, 1'b0);
            check("halt_no_order", 32'(bus.order_valid), 32'd0);
            check("halt_drop",     32'(drop_count),      32'd0);
        end
        halt_clear = 1'b1;
        drive_sample(32'h0005_0000, 1'b1, 1'b1);
        halt_clear = 1'b0;
        check("clear_kill_same_cycle", 32'(halted), 32'd1);
        halt_clear = 1'b1;
        step();
        halt_clear = 1'b0;
        check("halt_cleared", 32'(halted), 32'd0);
        drive_sample(32'h0005_0000, 1'b1, 1'b0);
        check("post_halt_valid", 32'(bus.order_valid), 32'd1);
        check("post_halt_qty",   32'(bus.order_qty),   32'd5);
        check("post_halt_side",  32'(bus.order_side),  32'd1);
        take_order();

        // quantity saturation and threshold boundaries
        do_reset();
        drive_sample(32'h7FFF_0000, 1'b1, 1'b0);
        check("max_buy_side", 32'(bus.order_side), 32'd1);
        check("max_buy_qty",  32'(bus.order_qty),  32'd100);
        take_order();
        drive_sample(32'h8000_0000, 1'b1, 1'b0);
        check("min_sell_side", 32'(bus.order_side), 32'd0);
        check("min_sell_qty",  32'(bus.order_qty),  32'd100);
        take_order();
        drive_sample(32'h0000_4000, 1'b1, 1'b0);
        check("quarter_valid", 32'(bus.order_valid), 32'd0);
        check("quarter_drop",  32'(drop_count),      32'd0);
        drive_sample(32'h0000_8000, 1'b0, 1'b0);
        check("half_noallow_valid", 32'(bus.order_valid), 32'd0);
        check("half_noallow_drop",  32'(drop_count),      32'd1);
        drive_sample(32'hFFFF_8000, 1'b1, 1'b0);
        check("neg_half_valid", 32'(bus.order_valid), 32'd1);
        check("neg_half_side",  32'(bus.order_side),  32'd0);
        check("neg_half_qty",   32'(bus.order_qty),   32'd1);
        take_order();
        drive_sample(32'hFFFF_8001, 1'b1, 1'b0);
        check("above_sell_valid", 32'(bus.order_valid), 32'd0);
        check("above_sell_drop",  32'(drop_count),      32'd1);

        // reset while an order waits for the consumer
        drive_sample(32'h0002_8000, 1'b1, 1'b0);
        check("pre_rst_valid", 32'(bus.order_valid), 32'd1);
        check("pre_rst_seq",   32'(bus.order_seq),   32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(bus.order_valid), 32'd0);
        check("mid_rst_seq",      32'(bus.order_seq),   32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready),    32'd1);
        check("mid_rst_qty",      32'(bus.order_qty),   32'd0);
        check("mid_rst_drop",     32'(drop_count),      32'd0);
        step();
        rst_n = 1'b1;
        drive_sample(32'h0002_8000, 1'b1, 1'b0);
        check("post_rst_valid", 32'(bus.order_valid), 32'd1);
        check("post_rst_qty",   32'(bus.order_qty),   32'd2);
        check("post_rst_seq",   32'(bus.order_seq),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/order_gen.md
ORDER_GEN -- requirements
Module: order_gen

Interface
REQ-001 Parameter BUY_THRESH, 32'sh0000_8000 (+0.5 Q16.16), signal at or above which a buy is generated.
REQ-002 Parameter SELL_THRESH, 32'shFFFF_8000 (-0.5 Q16.16), signal at or below which a sell is generated.
REQ-003 Parameter COOLDOWN_CYCLES, 4, cycles after an order handshake during which no new order is generated.
REQ-004 Parameter MAX_QTY, 100, maximum order quantity, integer units.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  upstream sample valid.
REQ-008 in_ready  out  1  block accepts sample this cycle.
REQ-009 signal_in  in  32 signed  trade signal, Q16.16.
REQ-010 allow_trade_in  in  1  risk permission for this sample.
REQ-011 kill_switch_in  in  1  risk kill request for this sample.
REQ-012 halt_clear  in  1  single-cycle operator pulse releasing HALTED.
REQ-013 order_valid  out  1  order available.
REQ-014 order_ready  in  1  downstream accepts order.
REQ-015 order_side  out  1  1 = buy, 0 = sell.
REQ-016 order_qty  out  16  unsigned quantity, 1..MAX_QTY.
REQ-017 order_seq  out  16  sequence number of presented order.
REQ-018 halted  out  1  high while in HALTED.
REQ-019 drop_count  out  16  count of suppressed threshold crossings.

Function
REQ-020 Sample accepted iff in_valid && in_ready; order handshake iff order_valid && order_ready.
REQ-021 States IDLE, HOLD, COOLDOWN, HALTED; in_ready = 1 in all states except HOLD.
REQ-022 Crossing = signed signal_in >= BUY_THRESH (buy) or <= SELL_THRESH (sell); otherwise no crossing.
REQ-023 qty = clamp(integer part of |signal_in|, 1, MAX_QTY); |0x8000_0000| saturates to 0x7FFF_FFFF before clamping.
REQ-024 IDLE accept: kill -> HALTED, no order; else crossing && allow -> HOLD with side/qty registered; else crossing && !allow -> drop_count+1, stay IDLE; else stay IDLE.
REQ-025 order_valid rises the cycle after the accepting edge (latency 1); side/qty/seq held stable while order_valid && !order_ready.
REQ-026 HOLD: on handshake order_seq increments (wraps 0xFFFF -> 0) and state -> COOLDOWN with counter = COOLDOWN_CYCLES, or -> IDLE if COOLDOWN_CYCLES = 0.
REQ-027 COOLDOWN: counter decrements every cycle; leaves to IDLE on the edge where counter is 1; accepted crossing -> drop_count+1, no order; accepted kill -> HALTED immediately.
REQ-028 HALTED: samples accepted and discarded, drop_count unchanged; halt_clear -> IDLE next edge; halt_clear ignored in other states.
REQ-029 HALTED with accepted kill and halt_clear same cycle: remain HALTED.
REQ-030 drop_count saturates at 0xFFFF.
REQ-031 kill is only sampled on accepted samples; a pending HOLD order is delivered before kill can be observed.

Reset
REQ-032 On rst_n low: state IDLE, in_ready 1, order_valid 0, order_side 0, order_qty 0, order_seq 0, halted 0, drop_count 0, cooldown counter 0; reset mid-HOLD discards the pending order.

Structure
REQ-033 fxp_pkg gains order-state enum, order_side typedef, Q16.16 threshold defaults and a saturating-abs function.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 signal 0x0002_8000 (+2.5), allow=1 -> next cycle order_valid, side=1, qty=2, seq=0.
REQ-036 signal 0xFFF0_0000 (-16), allow=1, order_ready low 3 cycles -> sell qty=16 held stable, in_ready 0, seq becomes 1 after handshake.
REQ-037 two buys back-to-back, COOLDOWN_CYCLES=4 -> second sample during cooldown yields no order, drop_count=1.
REQ-038 kill=1 in IDLE -> halted=1, samples of +5.0 produce no order; halt_clear pulse -> IDLE, next +5.0 gives qty=5.
REQ-039 signal 0x7FFF_0000 and 0x8000_0000 -> qty=100 buy and sell respectively; signal 0x0000_4000 -> no order, drop_count unchanged.
REQ-040 rst_n asserted while order_valid=1 waiting -> order_valid 0, seq 0, state IDLE within same cycle.
